// File: rtl/rv32_cache_pkg.sv
// rv32_cache_pkg: shared cache geometry, FSM encoding and address-field helpers
//  LINES_DEF/LINE_WORDS_DEF : default geometry
//  OFF_W/IDX_W/TAG_W         : field widths for the default geometry
//  addrOff/addrIdx/addrTag   : extract word offset, line index, tag from a byte address
//  lineBase                  : byte address of the first word of the containing line
package rv32_cache_pkg;
  localparam int LINES_DEF = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OFF_W = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  typedef enum logic {IDLE, REFILL} cacheState_t;
  function automatic logic [31:0] addrOff(input logic [31:0] a, input int offW);
    return (a >> 2) & ((32'd1 << offW) - 32'd1);
  endfunction
  function automatic logic [31:0] addrIdx(input logic [31:0] a, input int offW, input int idxW);
    return (a >> (offW + 2)) & ((32'd1 << idxW) - 32'd1);
  endfunction
  function automatic logic [31:0] addrTag(input logic [31:0] a, input int offW, input int idxW);
    return a >> (offW + idxW + 2);
  endfunction
  function automatic logic [31:0] lineBase(input logic [31:0] a, input int offW);
    return a & ~((32'd1 << (offW + 2)) - 32'd1);
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag, valid and data arrays of the direct-mapped instruction cache
//  iCLK, iRST           : clock, async active-high reset (clears valid bits only)
//  iFlush               : invalidate every line; wins over a same-edge valid write
//  iRdIdx, iRdOff       : async read port -> oRdData, oRdTag, oRdValid
//  iWrEn/iWrIdx/iWrOff/iWrData : sync word write
//  iTagWe/iTag/iValid   : sync tag and valid write for line iWrIdx
module icache_line_store #(
  parameter int LINES = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W = 26
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iFlush,
  input  logic [$clog2(LINES)-1:0]      iRdIdx,
  input  logic [$clog2(LINE_WORDS)-1:0] iRdOff,
  output logic [31:0]                   oRdData,
  output logic [TAG_W-1:0]              oRdTag,
  output logic                          oRdValid,
  input  logic                          iWrEn,
  input  logic [$clog2(LINES)-1:0]      iWrIdx,
  input  logic [$clog2(LINE_WORDS)-1:0] iWrOff,
  input  logic [31:0]                   iWrData,
  input  logic                          iTagWe,
  input  logic [TAG_W-1:0]              iTag,
  input  logic                          iValid
);
  logic [31:0] dataRam [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tagRam [LINES];
  logic [LINES-1:0] valid;
  assign oRdData = dataRam[{iRdIdx, iRdOff}];
  assign oRdTag = tagRam[iRdIdx];
  assign oRdValid = valid[iRdIdx];
  always_ff @(posedge iCLK) begin
    if (iWrEn) dataRam[{iWrIdx, iWrOff}] <= iWrData;
    if (iTagWe) tagRam[iWrIdx] <= iTag;
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) valid <= '0;
    else if (iFlush) valid <= '0;
    else if (iTagWe) valid[iWrIdx] <= iValid;
  end
endmodule

// File: rtl/icache_dm_rv32.sv
// icache_dm_rv32: direct-mapped read-only instruction cache with word-serial line refill
//  iCLK, iRST        : clock, async active-high reset
//  iPCADDR           : fetch byte address; oPCDATA valid when oStallI=0, else 0
//  oStallI           : word not available this cycle
//  iFlush            : one-cycle pulse invalidating all lines
//  oMemReq/oMemAddr  : backing-memory word request, held until iMemAck
//  iMemAck/iMemData  : one-cycle read response for the current oMemAddr
module icache_dm_rv32
  import rv32_cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iPCADDR,
  output logic [31:0] oPCDATA,
  output logic        oStallI,
  input  logic        iFlush,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemData
);
  localparam int offW = $clog2(LINE_WORDS);
  localparam int idxW = $clog2(LINES);
  localparam int tagW = 30 - offW - idxW;
  cacheState_t state;
  logic [offW-1:0] cnt, pcOff;
  logic [idxW-1:0] pcIdx, fillIdx;
  logic [tagW-1:0] pcTag, fillTag, rdTag;
  logic [31:0] fillBase, rdData;
  logic flushPend, rdValid, hit, beat, lastBeat;
  assign pcOff = offW'(addrOff(iPCADDR, offW));
  assign pcIdx = idxW'(addrIdx(iPCADDR, offW, idxW));
  assign pcTag = tagW'(addrTag(iPCADDR, offW, idxW));
  assign fillIdx = idxW'(addrIdx(fillBase, offW, idxW));
  assign fillTag = tagW'(addrTag(fillBase, offW, idxW));
  assign hit = rdValid && rdTag == pcTag;
  assign oStallI = !(state == IDLE && hit);
  assign oPCDATA = oStallI ? '0 : rdData;
  // acks outside an active request are ignored
  assign beat = state == REFILL && oMemReq && iMemAck;
  assign lastBeat = beat && cnt == offW'(LINE_WORDS - 1);
  // a flush seen at any point of the refill, including the final beat, leaves the line invalid
  icache_line_store #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(tagW)) store (
    .iCLK(iCLK), .iRST(iRST), .iFlush(iFlush),
    .iRdIdx(pcIdx), .iRdOff(pcOff), .oRdData(rdData), .oRdTag(rdTag), .oRdValid(rdValid),
    .iWrEn(beat), .iWrIdx(fillIdx), .iWrOff(cnt), .iWrData(iMemData),
    .iTagWe(lastBeat), .iTag(fillTag), .iValid(!flushPend)
  );
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      oMemReq <= 1'b0;
      oMemAddr <= '0;
      cnt <= '0;
      fillBase <= '0;
      flushPend <= 1'b0;
    end else if (state == IDLE) begin
      flushPend <= 1'b0;
      if (!hit) begin
        state <= REFILL;
        oMemReq <= 1'b1;
        oMemAddr <= lineBase(iPCADDR, offW);
        fillBase <= lineBase(iPCADDR, offW);
        cnt <= '0;
      end
    end else begin
      if (iFlush) flushPend <= 1'b1;
      if (beat) begin
        cnt <= cnt + offW'(1);
        oMemAddr <= oMemAddr + 32'd4;
        if (lastBeat) begin
          state <= IDLE;
          oMemReq <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_dm_rv32.sv
// tb_icache_dm_rv32: self-checking bench for icache_dm_rv32 with a word-serial memory model
module tb_icache_dm_rv32;
  logic clk = 1'b0;
  logic iRST, iFlush, iMemAck, oStallI, oMemReq;
  logic [31:0] iPCADDR, oPCDATA, oMemAddr, iMemData;
  int tests = 0, fails = 0;
  int ackDelay = 0, waitCnt = 0, reqCnt = 0;
  logic [31:0] heldAddr = '0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int stalls;
    int reqs;
  } vec_t;
  vec_t tbl[9];
  vec_t expQ[$];
  logic [31:0] expReq[$];

  always #5 clk = ~clk;

  icache_dm_rv32 dut (
    .iCLK(clk), .iRST(iRST), .iPCADDR(iPCADDR), .oPCDATA(oPCDATA), .oStallI(oStallI),
    .iFlush(iFlush), .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemData(iMemData)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: word at byte address A holds A+0x13; ack after ackDelay idle cycles per beat
  always @(negedge clk) begin
    if (iRST || !oMemReq) begin
      iMemAck = 1'b0;
      waitCnt = 0;
      if (iRST) expReq.delete();
    end else begin
      if (waitCnt > 0) chk("addr_hold", oMemAddr, heldAddr);
      heldAddr = oMemAddr;
      if (waitCnt >= ackDelay) begin
        iMemAck = 1'b1;
        iMemData = oMemAddr + 32'h13;
        reqCnt++;
        waitCnt = 0;
        if (expReq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got addr %h expected no request", oMemAddr);
        end else chk("req_addr", oMemAddr, expReq.pop_front());
      end else begin
        iMemAck = 1'b0;
        waitCnt++;
      end
    end
  end

  // called before the posedge of the cycle in which the address is presented
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stalls, input int reqs);
    vec_t e;
    int n, r0;
    e.addr = a; e.data = d; e.stalls = stalls; e.reqs = reqs;
    expQ.push_back(e);
    for (int i = 0; i < reqs; i++) expReq.push_back((a & ~32'hF) + 32'(4 * (i % 4)));
    r0 = reqCnt;
    iPCADDR = a;
    iFlush = 1'b0;
    #1;
    n = 0;
    while (oStallI && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    e = expQ.pop_front();
    chk($sformatf("stalls@%h", e.addr), 32'(n), 32'(e.stalls));
    chk($sformatf("data@%h", e.addr), oPCDATA, e.data);
    chk($sformatf("reqs@%h", e.addr), 32'(reqCnt - r0), 32'(e.reqs));
    chk($sformatf("reqq@%h", e.addr), 32'(expReq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    tbl[0] = '{32'h000, 32'h013, 5, 4};
    tbl[1] = '{32'h004, 32'h017, 0, 0};
    tbl[2] = '{32'h008, 32'h01B, 0, 0};
    tbl[3] = '{32'h00C, 32'h01F, 0, 0};
    tbl[4] = '{32'h104, 32'h117, 5, 4};
    tbl[5] = '{32'h000, 32'h013, 5, 4};
    tbl[6] = '{32'h010, 32'h023, 5, 4};
    tbl[7] = '{32'h014, 32'h027, 0, 0};
    tbl[8] = '{32'h000, 32'h013, 0, 0};
    iRST = 1'b1; iFlush = 1'b0; iMemAck = 1'b0; iMemData = '0; iPCADDR = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(oStallI), 32'd1);
    chk("rst_req", 32'(oMemReq), 32'd0);
    chk("rst_addr", oMemAddr, 32'd0);
    chk("rst_data", oPCDATA, 32'd0);
    @(negedge clk);
    iRST = 1'b0;
    for (int i = 0; i < 9; i++) fetch(tbl[i].addr, tbl[i].data, tbl[i].stalls, tbl[i].reqs);
    // slow memory: 3 idle cycles before each ack
    ackDelay = 3;
    fetch(32'h040, 32'h053, 17, 4);
    ackDelay = 0;
    // flush mid-refill: completed line stays invalid and is fetched again
    fork
      fetch(32'h200, 32'h213, 10, 8);
      begin
        repeat (2) @(negedge clk);
        iFlush = 1'b1;
        @(negedge clk);
        iFlush = 1'b0;
      end
    join
    fetch(32'h204, 32'h217, 0, 0);
    // flush in idle: this cycle still hits, afterwards everything misses
    iFlush = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(oStallI), 32'd0);
    chk("flush_idle_data", oPCDATA, 32'h217);
    @(negedge clk);
    fetch(32'h204, 32'h217, 5, 4);
    fetch(32'h014, 32'h027, 5, 4);
    // reset after the first beat of a refill
    expReq.push_back(32'h300);
    r0 = reqCnt;
    iPCADDR = 32'h300;
    for (int k = 0; k < 50 && reqCnt == r0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_beats", 32'(reqCnt - r0), 32'd1);
    @(posedge clk);
    #2;
    chk("mid_req", 32'(oMemReq), 32'd1);
    chk("mid_addr", oMemAddr, 32'h304);
    iRST = 1'b1;
    #1;
    chk("async_rst_req", 32'(oMemReq), 32'd0);
    chk("async_rst_addr", oMemAddr, 32'd0);
    chk("async_rst_stall", 32'(oStallI), 32'd1);
    repeat (2) @(negedge clk);
    iRST = 1'b0;
    #1;
    fetch(32'h300, 32'h313, 5, 4);
    fetch(32'h30C, 32'h31F, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
